// File: rtl/bitstuff_nrzi_encode.sv
// ---------------------------------------------------------------------------
// bitstuff_nrzi_encode
//
// Purpose: USB-style transmit back end. It takes a serial packet bit stream,
// inserts a stuffed 0 after STUFF_LEN consecutive data 1s, and NRZI-encodes
// the result for the downstream DP/DM line encoder. The encoder state is
// seeded as if a SYNC pattern was just sent: the last line level is K (0) and
// the SYNC's final data 1 already counts toward the stuffing run.
//
// Parameters:
//   STUFF_LEN     consecutive data-1 count that forces a stuffed 0 (2..7)
//
// Ports:
//   clock         single clock, all state updates on its rising edge
//   reset_n       synchronous, active-low reset
//   in_bit        serial packet bit (LSB-first order already applied)
//   in_valid      in_bit valid; high for the whole packet, held across stalls
//   in_ready      block accepts in_bit this cycle (transfer = valid & ready)
//   enc_done      one-cycle pulse from the DP/DM encoder when EOP is complete
//   nrzi_out_bit  NRZI line level, 1 = J, 0 = K (0 when not sending)
//   nrzi_sending  nrzi_out_bit valid; contiguous for the whole packet
// ---------------------------------------------------------------------------
module bitstuff_nrzi_encode #(
  parameter int STUFF_LEN = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  input  logic enc_done,
  output logic nrzi_out_bit,
  output logic nrzi_sending
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] STUFF     = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);

  logic [1:0] state_reg, state_next;
  logic [2:0] ones_reg, ones_next;
  logic       prev_reg, prev_next;
  logic       out_reg, out_next;
  logic       sending_reg, sending_next;

  // Encoding of the data bit presented this cycle. In IDLE the encoder is
  // re-seeded (level K, one 1 already counted) so every packet starts fresh,
  // regardless of what the previous packet left in the registers.
  logic       base_level;
  logic [2:0] base_ones;
  logic       data_level;
  logic [2:0] data_ones;

  always_comb begin
    base_level = (state_reg == IDLE) ? 1'b0 : prev_reg;
    base_ones  = (state_reg == IDLE) ? 3'd1 : ones_reg;
    // NRZI: a data 0 toggles the line, a data 1 holds it.
    data_level = in_bit ? base_level : ~base_level;
    data_ones  = in_bit ? (base_ones + 3'd1) : 3'd0;
  end

  assign in_ready = (state_reg == IDLE) || (state_reg == SEND);

  always_comb begin
    state_next   = state_reg;
    ones_next    = ones_reg;
    prev_next    = prev_reg;
    out_next     = 1'b0;
    sending_next = 1'b0;

    case (state_reg)
      IDLE, SEND: begin
        if (in_valid) begin
          prev_next    = data_level;
          ones_next    = data_ones;
          out_next     = data_level;
          sending_next = 1'b1;
          // A stuff is still owed even if this was the packet's last bit;
          // STUFF runs before SEND gets to see in_valid low.
          if (in_bit && (data_ones == STUFF_CNT)) begin
            state_next = STUFF;
          end else begin
            state_next = SEND;
          end
        end else if (state_reg == SEND) begin
          // End of packet: sending drops at this edge, then wait for EOP.
          state_next = WAIT_DONE;
        end
      end

      STUFF: begin
        // Stuffed 0 toggles the line; upstream is stalled for this cycle.
        prev_next    = ~prev_reg;
        out_next     = ~prev_reg;
        sending_next = 1'b1;
        ones_next    = 3'd0;
        state_next   = SEND;
      end

      WAIT_DONE: begin
        if (enc_done) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      ones_reg    <= 3'd0;
      prev_reg    <= 1'b0;
      out_reg     <= 1'b0;
      sending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ones_reg    <= ones_next;
      prev_reg    <= prev_next;
      out_reg     <= out_next;
      sending_reg <= sending_next;
    end
  end

  assign nrzi_out_bit = out_reg;
  assign nrzi_sending = sending_reg;

endmodule

// File: tb/tb_bitstuff_nrzi_encode.sv
// ---------------------------------------------------------------------------
// tb_bitstuff_nrzi_encode
//
// Self-checking bench for bitstuff_nrzi_encode (STUFF_LEN = 6). Directed
// packets cover the worked examples, WAIT_DONE holding, and mid-packet
// reset; randomized packets are checked against a two-stage reference
// (bit stuffing on the data list, then NRZI on the stuffed list).
// ---------------------------------------------------------------------------
module tb_bitstuff_nrzi_encode;

  localparam int STUFF_LEN = 6;

  logic clock    = 1'b0;
  logic reset_n  = 1'b0;
  logic in_bit   = 1'b0;
  logic in_valid = 1'b0;
  logic enc_done = 1'b0;
  logic in_ready;
  logic nrzi_out_bit;
  logic nrzi_sending;

  int n_cmp = 0;
  int n_bad = 0;

  bit pkt_q[$];
  bit exp_q[$];
  bit cap_q[$];
  int exp_stalls;
  int obs_stalls;
  int max_repeat;
  int first_cyc;
  int idle_level_bad;
  bit pkt_ended;

  bitstuff_nrzi_encode #(.STUFF_LEN(STUFF_LEN)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_bit       (in_bit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .enc_done     (enc_done),
    .nrzi_out_bit (nrzi_out_bit),
    .nrzi_sending (nrzi_sending)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Packet bits written MSB-first in the literal = first bit sent.
  task automatic load_pkt(input logic [15:0] lit, input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(lit[n-1-i]);
  endtask

  // Reference: stuff first (run seeded at 1 by SYNC), then NRZI from K.
  task automatic build_model();
    bit stuffed[$];
    int run;
    bit lvl;
    stuffed.delete();
    exp_q.delete();
    exp_stalls = 0;
    run = 1;
    for (int i = 0; i < pkt_q.size(); i++) begin
      stuffed.push_back(pkt_q[i]);
      run = pkt_q[i] ? run + 1 : 0;
      if (run == STUFF_LEN) begin
        stuffed.push_back(1'b0);
        run = 0;
        // A stuff after the last bit happens after in_valid has dropped.
        if (i != pkt_q.size() - 1) exp_stalls++;
      end
    end
    lvl = 1'b0;
    for (int k = 0; k < stuffed.size(); k++) begin
      if (!stuffed[k]) lvl = !lvl;
      exp_q.push_back(lvl);
    end
  endtask

  // Drive pkt_q as one contiguous in_valid run, capture the output until
  // nrzi_sending falls, then check it against the reference.
  task automatic run_packet(input string tag, input bit noise);
    int  idx = 0;
    int  cyc = 0;
    bit  started = 0;
    bit  xfer;
    int  rep;
    bit  prev;
    cap_q.delete();
    obs_stalls = 0;
    first_cyc = -1;
    idle_level_bad = 0;
    pkt_ended = 0;
    build_model();
    in_valid = 1'b1;
    in_bit   = pkt_q[0];
    while (!pkt_ended && cyc < 1000) begin
      @(negedge clock);
      xfer = in_valid && in_ready;
      if (in_valid && !in_ready) obs_stalls++;
      // enc_done outside WAIT_DONE must have no effect.
      enc_done = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
      cyc++;
      if (nrzi_sending) begin
        if (!started) first_cyc = cyc;
        started = 1;
        cap_q.push_back(nrzi_out_bit);
      end else begin
        if (nrzi_out_bit) idle_level_bad++;
        if (started) pkt_ended = 1;
      end
      if (xfer) begin
        idx++;
        if (idx < pkt_q.size()) begin
          in_bit = pkt_q[idx];
        end else begin
          in_valid = 1'b0;
          in_bit   = 1'($urandom_range(0, 1));
        end
      end
    end
    enc_done = 1'b0;

    chk1($sformatf("%s ended", tag), pkt_ended, 1'b1);
    chkn($sformatf("%s first-latency", tag), first_cyc, 1);
    chkn($sformatf("%s length", tag), cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      chk1($sformatf("%s bit%0d", tag, i), cap_q[i], exp_q[i]);
    chkn($sformatf("%s stalls", tag), obs_stalls, exp_stalls);
    chkn($sformatf("%s idle-level", tag), idle_level_bad, 0);
    // Longest run of repeated levels; the seed counts as one repeat.
    prev = 1'b0;
    rep = 1;
    max_repeat = 1;
    for (int i = 0; i < cap_q.size(); i++) begin
      rep = (cap_q[i] == prev) ? rep + 1 : 0;
      prev = cap_q[i];
      if (rep > max_repeat) max_repeat = rep;
    end
    chk1($sformatf("%s run-limit", tag), (max_repeat <= STUFF_LEN), 1'b1);
  endtask

  task automatic chk_lit(input string tag, input logic [15:0] lit, input int n);
    chkn($sformatf("%s lit-length", tag), cap_q.size(), n);
    for (int i = 0; i < n && i < cap_q.size(); i++)
      chk1($sformatf("%s lit-bit%0d", tag, i), cap_q[i], lit[n-1-i]);
  endtask

  // In WAIT_DONE: hold for 'hold' cycles, then pulse enc_done.
  task automatic finish_packet(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      chk1($sformatf("%s wait-ready c%0d", tag, i), in_ready, 1'b0);
      chk1($sformatf("%s wait-sending c%0d", tag, i), nrzi_sending, 1'b0);
      tick();
    end
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    chk1($sformatf("%s ready-after-done", tag), in_ready, 1'b1);
    chk1($sformatf("%s idle-sending", tag), nrzi_sending, 1'b0);
  endtask

  initial begin
    int n;
    int hold;

    // Reset state
    tick();
    tick();
    chk1("reset in_ready", in_ready, 1'b1);
    chk1("reset sending", nrzi_sending, 1'b0);
    chk1("reset out_bit", nrzi_out_bit, 1'b0);
    reset_n = 1'b1;
    tick();
    chk1("post-reset in_ready", in_ready, 1'b1);
    chk1("post-reset sending", nrzi_sending, 1'b0);

    // 1,0,0,1 -> 0,1,0,0
    load_pkt(16'b1001, 4);
    run_packet("ex1001", 1'b0);
    chk_lit("ex1001", 16'b0100, 4);
    finish_packet("ex1001", 3);

    // 1,1,1,1,1,0,0 -> 0,0,0,0,0,1(stuff),0,1 with one stall
    load_pkt(16'b1111100, 7);
    run_packet("stuffmid", 1'b0);
    chk_lit("stuffmid", 16'b00000101, 8);
    chkn("stuffmid lit-stalls", obs_stalls, 1);
    finish_packet("stuffmid", 0);

    // 0,1,1,1,1,1,1 -> 1,1,1,1,1,1,1,0(stuff); 8 sending cycles
    load_pkt(16'b0111111, 7);
    run_packet("stufflast", 1'b0);
    chk_lit("stufflast", 16'b11111110, 8);
    chkn("stufflast stalls0", obs_stalls, 0);
    finish_packet("stufflast", 1);

    // WAIT_DONE with in_valid held high for 10 cycles
    load_pkt(16'b110, 3);
    run_packet("prewait", 1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    finish_packet("holdvalid", 10);
    load_pkt(16'b10, 2);
    run_packet("afterwait", 1'b0);
    chk_lit("afterwait", 16'b01, 2);
    finish_packet("afterwait", 0);

    // Reset during the 3rd bit of a packet
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    in_bit = 1'b0;
    tick();
    chk1("midrst sending-before", nrzi_sending, 1'b1);
    in_bit  = 1'b1;
    reset_n = 1'b0;
    tick();
    chk1("midrst sending", nrzi_sending, 1'b0);
    chk1("midrst out_bit", nrzi_out_bit, 1'b0);
    chk1("midrst in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    chk1("midrst idle sending", nrzi_sending, 1'b0);
    load_pkt(16'b10, 2);
    run_packet("postrst", 1'b0);
    chk_lit("postrst", 16'b01, 2);
    finish_packet("postrst", 0);

    // Randomized packets, 1..200 bits, biased toward 1s to exercise stuffing
    for (int p = 0; p < 25; p++) begin
      n = (p == 0) ? 1 : ((p == 1) ? 200 : int'($urandom_range(1, 200)));
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back($urandom_range(0, 99) < 78);
      hold = int'($urandom_range(0, 4));
      run_packet($sformatf("rnd%0d", p), 1'b1);
      finish_packet($sformatf("rnd%0d", p), hold);
      // Stray enc_done in IDLE is ignored.
      if ($urandom_range(0, 1) == 1) begin
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk1($sformatf("rnd%0d idle-done ready", p), in_ready, 1'b1);
        chk1($sformatf("rnd%0d idle-done sending", p), nrzi_sending, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
